// File: rtl/valid_pacer_if.sv
// Handshake bundle for valid_pacer: source-side ready/valid input, enable gate,
// and the paced issue pulse with payload and FIFO occupancy.
interface valid_pacer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic                         i_enable;
  logic                         i_valid;
  logic [DATA_W-1:0]            i_data;
  logic                         o_ready;
  logic                         o_valid;
  logic [DATA_W-1:0]            o_data;
  logic [$clog2(DEPTH+1)-1:0]   o_level;

  modport master (
    output i_enable, i_valid, i_data,
    input  o_ready, o_valid, o_data, o_level
  );

  modport slave (
    input  i_enable, i_valid, i_data,
    output o_ready, o_valid, o_data, o_level
  );
endinterface

// File: rtl/valid_pacer.sv
// Buffers ready/valid words in a DEPTH FIFO and issues them as 1-cycle pulses spaced >= LATENCY cycles.
// Empty-FIFO latency: accept at edge k, pulse after edge k+1; o_ready drops only when level == DEPTH.
module valid_pacer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  valid_pacer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int GAP_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              ready;
  logic              push;
  logic              pop;

  // Readiness looks only at level, so a full FIFO never accepts even while popping.
  assign ready = (level_q != LVL_W'(DEPTH));
  assign push  = bus.i_valid && ready;
  assign pop   = (level_q != '0) && bus.i_enable && (gap_q == '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    gap_d     = gap_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      o_valid_d = 1'b1;
      o_data_d  = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      gap_d     = GAP_W'(LATENCY - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      gap_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      gap_q     <= gap_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  // Storage is never read while level is 0, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.i_data;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_level = level_q;
endmodule
